core_inst_sequencer: RTL



---
 rtl/core_inst_pkg.sv | 42 ++++
 rtl/core_inst_sequencer_addr_gen.sv | 56 +++++
 rtl/core_inst_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: inst_q field positions, IDLE word, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a. Optional ACC phase is controlled by macro ACC_PHASE_EN (state code reserved always).
`timescale 1ns/1ps
package core_inst_pkg;

  localparam int INST_W = 34;

  // inst_q field positions
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LSB   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LSB   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both memories disabled (active-low CEN/WEN high), everything else quiet
  localparam logic [INST_W-1:0] INST_IDLE =
    (34'd1 << B_CEN_P) | (34'd1 << B_WEN_P) |
    (34'd1 << B_CEN_X) | (34'd1 << B_WEN_X);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD_W = 4'd1,
    ST_KERN   = 4'd2,
    ST_ACT    = 4'd3,
    ST_EXEC   = 4'd4,
    ST_DRAIN  = 4'd5,
    ST_OFIFO  = 4'd6,
    ST_ACC    = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

endpackage

// File: rtl/core_inst_sequencer_addr_gen.sv
// Loop counters (i = step within a phase, k = kernel position, o = output row) and SRAM address generation.
// Latency: counters update on the clock edge after a strobe; addresses are combinational from the counters.
// Backpressure: none; the FSM stalls simply by withholding increment strobes.
`timescale 1ns/1ps
module seq_addr_gen
  import core_inst_pkg::*;
#(
  parameter int row    = 8,
  parameter int ADDR_W = 11,
  parameter int KIJ_W  = 4,
  parameter int LEN_W  = 6,
  parameter int CNT_W  = 7,
  parameter logic [ADDR_W-1:0] W_BASE = 11'd1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic              k_clr,
  input  logic              k_inc,
  input  logic              o_clr,
  input  logic              o_inc,
  input  logic              sel_o,
  input  logic [LEN_W-1:0]  len,
  output logic [CNT_W-1:0]  i,
  output logic [KIJ_W-1:0]  k,
  output logic [LEN_W-1:0]  o,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] p_addr
);

  // Counters: clear wins over increment so a phase exit can restart at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i <= '0;
      k <= '0;
      o <= '0;
    end else begin
      if (i_clr)      i <= '0;
      else if (i_inc) i <= i + CNT_W'(1);
      if (k_clr)      k <= '0;
      else if (k_inc) k <= k + KIJ_W'(1);
      if (o_clr)      o <= '0;
      else if (o_inc) o <= o + LEN_W'(1);
    end
  end

  // Address arithmetic truncates to ADDR_W; range is the configurer's responsibility
  always_comb begin
    w_addr = W_BASE + ADDR_W'(k) * ADDR_W'(row) + ADDR_W'(i);
    a_addr = ADDR_W'(i);
    p_addr = ADDR_W'(k) * ADDR_W'(len) + (sel_o ? ADDR_W'(o) : ADDR_W'(i));
  end

endmodule

// File: rtl/core_inst_sequencer.sv
// Issues the 34-bit inst_q stream to core for one tile: weight load, kernel load, activation/execute, OFIFO drain per kij.
// Latency: registered outputs; a state's first instruction appears one cycle after entry, done 1 cycle after DONE entry.
// Backpressure: stalls in DRAIN (IDLE word) until ofifo_valid; optional ACC phase when ACC_PHASE_EN is defined.
`timescale 1ns/1ps
module core_inst_sequencer
  import core_inst_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 6,
  parameter int KIJ_W  = 4,
  parameter logic [ADDR_W-1:0] W_BASE = 11'd1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KIJ_W-1:0]  cfg_kij,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst_q,
  output logic              busy,
  output logic              done
);

  // Step counter must reach row+col-1 (KERN) and cfg_len (ACT)
  localparam int KW    = $clog2(row + col + 1);
  localparam int CNT_W = ((KW > LEN_W) ? KW : LEN_W) + 1;

  state_t            state, nxt;
  logic [KIJ_W-1:0]  kij_r;
  logic [LEN_W-1:0]  len_r;
  logic              cap;
  logic              i_clr, i_inc, k_clr, k_inc, o_clr, o_inc;
  logic [CNT_W-1:0]  i;
  logic [KIJ_W-1:0]  k;
  logic [LEN_W-1:0]  o;
  logic [ADDR_W-1:0] w_addr, a_addr, p_addr;
  logic [INST_W-1:0] inst_nxt;

  seq_addr_gen #(
    .row(row), .ADDR_W(ADDR_W), .KIJ_W(KIJ_W), .LEN_W(LEN_W),
    .CNT_W(CNT_W), .W_BASE(W_BASE)
  ) u_addr (
    .clk(clk), .reset(reset),
    .i_clr(i_clr), .i_inc(i_inc), .k_clr(k_clr), .k_inc(k_inc),
    .o_clr(o_clr), .o_inc(o_inc), .sel_o(state == ST_ACC),
    .len(len_r), .i(i), .k(k), .o(o),
    .w_addr(w_addr), .a_addr(a_addr), .p_addr(p_addr)
  );

  // Next-state and counter strobes
  always_comb begin
    nxt   = state;
    cap   = 1'b0;
    i_clr = 1'b0;
    i_inc = 1'b0;
    k_clr = 1'b0;
    k_inc = 1'b0;
    o_clr = 1'b0;
    o_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cap   = 1'b1;
          i_clr = 1'b1;
          k_clr = 1'b1;
          o_clr = 1'b1;
          nxt   = (cfg_kij == '0 || cfg_len == '0) ? ST_DONE : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (i == CNT_W'(row)) begin nxt = ST_KERN; i_clr = 1'b1; end
        else i_inc = 1'b1;
      end
      ST_KERN: begin
        if (i == CNT_W'(row + col - 1)) begin nxt = ST_ACT; i_clr = 1'b1; end
        else i_inc = 1'b1;
      end
      ST_ACT: begin
        if (i == CNT_W'(len_r)) begin nxt = ST_EXEC; i_clr = 1'b1; end
        else i_inc = 1'b1;
      end
      ST_EXEC: begin
        if (i + CNT_W'(1) == CNT_W'(len_r)) begin nxt = ST_DRAIN; i_clr = 1'b1; end
        else i_inc = 1'b1;
      end
      ST_DRAIN: begin
        if (ofifo_valid) nxt = ST_OFIFO;
      end
      ST_OFIFO: begin
        if (i + CNT_W'(1) == CNT_W'(len_r)) begin
          i_clr = 1'b1;
          if (k + KIJ_W'(1) == kij_r) begin
`ifdef ACC_PHASE_EN
            k_clr = 1'b1;
            o_clr = 1'b1;
            nxt   = ST_ACC;
`else
            nxt   = ST_DONE;
`endif
          end else begin
            k_inc = 1'b1;
            nxt   = ST_LOAD_W;
          end
        end else begin
          i_inc = 1'b1;
        end
      end
`ifdef ACC_PHASE_EN
      ST_ACC: begin
        // k is the inner loop, o the outer
        if (k + KIJ_W'(1) == kij_r) begin
          k_clr = 1'b1;
          if (o + LEN_W'(1) == len_r) nxt = ST_DONE;
          else o_inc = 1'b1;
        end else begin
          k_inc = 1'b1;
        end
      end
`endif
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Instruction word for the current state; l0_wr trails the xmem read by one cycle
  always_comb begin
    inst_nxt = INST_IDLE;
    case (state)
      ST_LOAD_W: begin
        if (i < CNT_W'(row)) begin
          inst_nxt[B_CEN_X] = 1'b0;
          inst_nxt[B_AX_LSB +: ADDR_W] = w_addr;
        end
        if (i != '0) inst_nxt[B_L0_WR] = 1'b1;
      end
      ST_KERN: begin
        inst_nxt[B_LOAD]  = 1'b1;
        inst_nxt[B_L0_RD] = 1'b1;
      end
      ST_ACT: begin
        if (i < CNT_W'(len_r)) begin
          inst_nxt[B_CEN_X] = 1'b0;
          inst_nxt[B_AX_LSB +: ADDR_W] = a_addr;
        end
        if (i != '0) inst_nxt[B_L0_WR] = 1'b1;
      end
      ST_EXEC: begin
        inst_nxt[B_EXEC]  = 1'b1;
        inst_nxt[B_L0_RD] = 1'b1;
      end
      ST_OFIFO: begin
        inst_nxt[B_OFIFO_RD] = 1'b1;
        inst_nxt[B_CEN_P]    = 1'b0;
        inst_nxt[B_WEN_P]    = 1'b0;
        inst_nxt[B_AP_LSB +: ADDR_W] = p_addr;
      end
`ifdef ACC_PHASE_EN
      ST_ACC: begin
        inst_nxt[B_ACC]   = 1'b1;
        inst_nxt[B_CEN_P] = 1'b0;
        inst_nxt[B_AP_LSB +: ADDR_W] = p_addr;
      end
`endif
      default: ;
    endcase
  end

  // State, captured configuration and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      kij_r  <= '0;
      len_r  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      inst_q <= INST_IDLE;
    end else begin
      state <= nxt;
      if (cap) begin
        kij_r <= cfg_kij;
        len_r <= cfg_len;
      end
      busy   <= (nxt != ST_IDLE);
      done   <= (state == ST_DONE);
      inst_q <= inst_nxt;
    end
  end

endmodule
